// File: rtl/button_debouncer.sv
// Dual-channel push-button conditioner: 2-FF synchroniser plus a stable-time
// counter FSM per channel, giving a clean active-low level and a one-cycle press pulse.
module button_debouncer #(
  parameter int CLOCK_FREQ     = 12000000,
  parameter int DEBOUNCE_COUNT = CLOCK_FREQ / 100
) (
  input  logic clk,
  input  logic rst_in_n,
  input  logic btn1_in_n,
  input  logic btn2_in_n,
  output logic req1_out_n,
  output logic req2_out_n,
  output logic press1_out,
  output logic press2_out
);

  localparam int CNT_W = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_COUNT - 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [1:0] btn_n;
  logic [1:0] req_n;
  logic [1:0] press;

  assign btn_n = {btn2_in_n, btn1_in_n};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic             sync0_reg, sync1_reg;
      state_t           state_reg, state_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             req_n_reg, req_n_next;
      logic             press_reg, press_next;

      // Synchroniser resets to the released level so reset release never looks like a press.
      always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
          sync0_reg <= 1'b1;
          sync1_reg <= 1'b1;
        end else begin
          sync0_reg <= btn_n[gi];
          sync1_reg <= sync0_reg;
        end
      end

      always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
          state_reg <= RELEASED;
          cnt_reg   <= '0;
          req_n_reg <= 1'b1;
          press_reg <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          req_n_reg <= req_n_next;
          press_reg <= press_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
          RELEASED: begin
            if (!sync1_reg) begin
              state_next = PRESS_WAIT;
              cnt_next   = '0;
            end
          end
          PRESS_WAIT: begin
            if (sync1_reg) begin
              state_next = RELEASED;
              cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
              state_next = PRESSED;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
          PRESSED: begin
            if (sync1_reg) begin
              state_next = RELEASE_WAIT;
              cnt_next   = '0;
            end
          end
          RELEASE_WAIT: begin
            // A bounce back to pressed returns silently, without a second pulse.
            if (!sync1_reg) begin
              state_next = PRESSED;
              cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
              state_next = RELEASED;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
          default: begin
            state_next = RELEASED;
            cnt_next   = '0;
          end
        endcase
      end

      always_comb begin
        req_n_next = req_n_reg;
        press_next = 1'b0;
        case (state_reg)
          PRESS_WAIT: begin
            if (!sync1_reg && cnt_reg == CNT_LAST) begin
              req_n_next = 1'b0;
              press_next = 1'b1;
            end
          end
          RELEASE_WAIT: begin
            if (sync1_reg && cnt_reg == CNT_LAST) begin
              req_n_next = 1'b1;
            end
          end
          default: begin
            req_n_next = req_n_reg;
          end
        endcase
      end

      assign req_n[gi] = req_n_reg;
      assign press[gi] = press_reg;
    end
  endgenerate

  assign req1_out_n = req_n[0];
  assign req2_out_n = req_n[1];
  assign press1_out = press[0];
  assign press2_out = press[1];

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_COUNT=4; latencies are counted
// in rising edges from the edge that first captures the new raw level (index 0).
module tb_button_debouncer;

  logic clk = 1'b0;
  logic rst_in_n;
  logic btn1_in_n, btn2_in_n;
  logic req1_out_n, req2_out_n;
  logic press1_out, press2_out;
  logic [1:0] req_n;

  int n_checks = 0;
  int n_errors = 0;
  int p1_cnt = 0;
  int p2_cnt = 0;
  int exp_p1 = 0;
  int exp_p2 = 0;
  int edges;

  button_debouncer #(
    .CLOCK_FREQ    (12000000),
    .DEBOUNCE_COUNT(4)
  ) dut (
    .clk       (clk),
    .rst_in_n  (rst_in_n),
    .btn1_in_n (btn1_in_n),
    .btn2_in_n (btn2_in_n),
    .req1_out_n(req1_out_n),
    .req2_out_n(req2_out_n),
    .press1_out(press1_out),
    .press2_out(press2_out)
  );

  always #5 clk = ~clk;

  assign req_n = {req2_out_n, req1_out_n};

  // Each high cycle of a press output is counted once, mid-cycle.
  always @(negedge clk) begin
    if (press1_out === 1'b1) p1_cnt++;
    if (press2_out === 1'b1) p2_cnt++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Call right after driving an input at a falling edge: the next rising edge is index 0.
  task automatic wait_req(input int ch, input logic lvl, output int e);
    bit found;
    found = 1'b0;
    e = -1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (req_n[ch] === lvl) begin
        e = i;
        found = 1'b1;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in_n  = 1'b0;
    btn1_in_n = 1'b0;
    btn2_in_n = 1'b1;

    // 1: reset held with button 1 pressed, then released with it still held
    repeat (5) @(negedge clk);
    check("rst_req1", int'(req1_out_n), 1);
    check("rst_press1", int'(press1_out), 0);
    check("rst_req2", int'(req2_out_n), 1);
    check("rst_press2", int'(press2_out), 0);
    check("rst_no_pulse", p1_cnt, 0);
    rst_in_n = 1'b1;
    wait_req(0, 1'b0, edges);
    check("rel_latency", edges, 6);
    check("rel_press1", int'(press1_out), 1);
    exp_p1++;

    // 2: clean release then clean press, held 100 cycles
    @(negedge clk);
    btn1_in_n = 1'b1;
    wait_req(0, 1'b1, edges);
    check("release_latency", edges, 6);
    @(negedge clk);
    btn1_in_n = 1'b0;
    wait_req(0, 1'b0, edges);
    check("press_latency", edges, 6);
    check("press_pulse_hi", int'(press1_out), 1);
    exp_p1++;
    @(posedge clk);
    #1;
    check("press_pulse_lo", int'(press1_out), 0);
    repeat (100) @(posedge clk);
    #1;
    check("hold_one_pulse", p1_cnt, exp_p1);
    check("hold_req1", int'(req1_out_n), 0);

    // 4: short release glitch (3 cycles) then sustained release
    @(negedge clk);
    btn1_in_n = 1'b1;
    repeat (3) @(negedge clk);
    btn1_in_n = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_req1", int'(req1_out_n), 0);
    check("glitch_no_pulse", p1_cnt, exp_p1);
    btn1_in_n = 1'b1;
    wait_req(0, 1'b1, edges);
    check("release2_latency", edges, 6);
    check("release2_press1", int'(press1_out), 0);

    // 3: bounce with 2-cycle spacing, then settle low
    @(negedge clk);
    btn1_in_n = 1'b0;
    repeat (2) @(negedge clk);
    btn1_in_n = 1'b1;
    repeat (2) @(negedge clk);
    btn1_in_n = 1'b0;
    repeat (2) @(negedge clk);
    btn1_in_n = 1'b1;
    repeat (2) @(negedge clk);
    check("bounce_req1", int'(req1_out_n), 1);
    check("bounce_no_pulse", p1_cnt, exp_p1);
    btn1_in_n = 1'b0;
    wait_req(0, 1'b0, edges);
    check("bounce_latency", edges, 6);
    exp_p1++;
    repeat (20) @(posedge clk);
    #1;
    check("bounce_one_pulse", p1_cnt, exp_p1);

    // 5: both buttons fall together
    @(negedge clk);
    btn1_in_n = 1'b1;
    wait_req(0, 1'b1, edges);
    check("sim_pre_release", edges, 6);
    @(negedge clk);
    btn1_in_n = 1'b0;
    btn2_in_n = 1'b0;
    wait_req(0, 1'b0, edges);
    check("sim_latency", edges, 6);
    check("sim_press1", int'(press1_out), 1);
    check("sim_press2", int'(press2_out), 1);
    check("sim_req2", int'(req2_out_n), 0);
    exp_p1++;
    exp_p2++;

    // 6: reset asserted while in PRESS_WAIT with counter at 2
    @(negedge clk);
    btn1_in_n = 1'b1;
    btn2_in_n = 1'b1;
    repeat (15) @(negedge clk);
    check("mid_pre_req1", int'(req1_out_n), 1);
    btn1_in_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_in_n = 1'b0;
    #1;
    check("mid_rst_req1", int'(req1_out_n), 1);
    check("mid_rst_press1", int'(press1_out), 0);
    check("mid_rst_req2", int'(req2_out_n), 1);
    repeat (3) @(negedge clk);
    rst_in_n = 1'b1;
    wait_req(0, 1'b0, edges);
    check("mid_latency", edges, 6);
    check("mid_press1", int'(press1_out), 1);
    exp_p1++;
    repeat (10) @(posedge clk);
    #1;
    check("total_p1", p1_cnt, exp_p1);
    check("total_p2", p2_cnt, exp_p2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Dual-channel push-button conditioner sitting directly upstream of the arbiter game top level.
- Per channel:
  - synchronises the raw active-low button input to clk;
  - rejects contact bounce with a stable-time counter FSM;
  - drives a clean active-low level for the game's req1_in/req2_in;
  - drives a one-cycle press pulse for optional event logic.
- The two channels are fully independent. No arbitration happens here; the game FSM decides the winner.

Parameters:
- CLOCK_FREQ, 12000000, system clock frequency in Hz.
- DEBOUNCE_COUNT, CLOCK_FREQ/100, consecutive synchronised cycles (10 ms at default) a new level must hold before it is accepted. Must be >= 1.
- CNT_W, $clog2(DEBOUNCE_COUNT+1), counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_in_n  input  1  asynchronous active-low reset.
- btn1_in_n  input  1  raw button 1, active-low (0 = pressed), asynchronous to clk.
- btn2_in_n  input  1  raw button 2, active-low, asynchronous to clk.
- req1_out_n  output  1  debounced button 1 level, active-low, registered.
- req2_out_n  output  1  debounced button 2 level, active-low, registered.
- press1_out  output  1  one-cycle high pulse on accepted button 1 press.
- press2_out  output  1  one-cycle high pulse on accepted button 2 press.

Behaviour:
- Reset (rst_in_n=0, async assert, sync release through normal clocking):
  - both 2-FF synchroniser stages = 1 (released);
  - FSM = RELEASED; counter = 0;
  - req*_out_n = 1; press*_out = 0.
- Synchroniser: sync0 <= btn_in_n, sync1 <= sync0. The FSM sees sync1 only.
- Per-channel FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - RELEASED: sync1=0 -> PRESS_WAIT, counter <= 0; else stay.
  - PRESS_WAIT:
    - sync1=1 -> RELEASED, counter <= 0 (bounce rejected, no output change);
    - sync1=0 and counter==DEBOUNCE_COUNT-1 -> PRESSED, req_out_n <= 0, press_out <= 1;
    - else counter <= counter+1.
  - PRESSED: sync1=1 -> RELEASE_WAIT, counter <= 0; else stay. press_out <= 0 on every cycle not entering PRESSED.
  - RELEASE_WAIT:
    - sync1=0 -> PRESSED, counter <= 0, no pulse;
    - sync1=1 and counter==DEBOUNCE_COUNT-1 -> RELEASED, req_out_n <= 1;
    - else counter <= counter+1.
- Latency:
  - Raw edge captured by sync0 at edge k -> WAIT entered at edge k+2 -> req_out_n changes at edge k+2+DEBOUNCE_COUNT, when the level stays stable.
  - press_out is high for exactly that one cycle.
- Counter never exceeds DEBOUNCE_COUNT-1 and never wraps.
- Any bounce inside a WAIT state restarts the full stable window.
- Holding the button pressed indefinitely gives one pulse only. No auto-repeat.
- Simultaneous presses: the channels are independent, so both pulses may assert on the same cycle.
- Reset mid-operation: all state returns to reset values immediately. No pulse is generated by reset release, even if the button is held. The press is accepted DEBOUNCE_COUNT+2 cycles after release of reset, counted from the first edge.
- Glitches shorter than one clock period may be missed entirely. This is acceptable.
- DEBOUNCE_COUNT=1: accept on the first WAIT cycle, so latency is k+3.

Test Plan:
(All with DEBOUNCE_COUNT=4.)
1. Reset held, btn1_in_n=0 -> req1_out_n=1, press1_out=0, req2_out_n=1. Reset released with button held -> req1_out_n=0 at 6th edge, single press1_out pulse.
2. Clean press: btn1_in_n 1->0 captured at edge k -> req1_out_n=0 and press1_out=1 at edge k+6. press1_out=0 at k+7. Held 100 cycles -> no further pulse.
3. Bounce: btn1_in_n toggles 0/1/0/1 with 2-cycle spacing, then stays 0 -> no output change during bounce. req1_out_n=0 exactly 6 edges after the last falling capture. Exactly one pulse.
4. Release: from PRESSED, btn1_in_n=1 for 3 cycles then 0 -> req1_out_n stays 0, no pulse. Sustained 1 -> req1_out_n=1 at k+6, press1_out stays 0.
5. Simultaneous: btn1_in_n and btn2_in_n fall on the same cycle -> press1_out and press2_out both high on the same cycle, k+6.
6. Mid-wait reset: assert rst_in_n=0 during PRESS_WAIT (counter=2) -> outputs immediately at reset values. After release with button still 0 -> full 6-edge latency again.
